// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch controller for a combinational, byte-addressed,
// big-endian instruction ROM. It reads one word per cycle from the PC, queues
// {word, pc} entries and hands them to issue over a valid/ready handshake.
// It also supports branch redirect/flush and stops fetching at end of ROM.
//
// Parameters
//   DEPTH     : queue entries (power of 2, >= 2)
//   ROM_BYTES : ROM size in bytes; last fetchable word address is ROM_BYTES-4
//   RESET_PC  : word-aligned PC loaded at reset
//
// Ports
//   clk, nrst          : clock, synchronous active-low reset
//   rom_nrd            : ROM read enable (active-low), low only on a fetch cycle
//   rom_addr           : ROM byte address (always the current PC)
//   rom_data           : ROM word, valid in the same cycle as rom_nrd=0
//   issue_valid/ready  : head entry handshake
//   issue_inst/pc      : head entry; hold last shown value while empty
//   redirect_valid/pc  : flush queue and restart fetch at redirect_pc & ~3
//   fetch_done         : fetch stopped (end of ROM, or halt when enabled)
//   queue_count        : occupied entries
//
// Optional feature macro: HALT_DETECT_EN
//   When defined, fetching the word 32'hFC000000 queues it and stops fetch.
module inst_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROM_BYTES = 100,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                       clk,
  input  logic                       nrst,
  output logic                       rom_nrd,
  output logic [31:0]                rom_addr,
  input  logic [31:0]                rom_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [31:0]                issue_inst,
  output logic [31:0]                issue_pc,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       fetch_done,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int unsigned PW        = $clog2(DEPTH);
  localparam int unsigned CW        = PW + 1;
  localparam logic [31:0] LAST_ADDR = 32'(ROM_BYTES - 4);
  localparam logic [31:0] RST_PC    = 32'(RESET_PC);
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  typedef enum logic {RUN, DONE} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  state_t          state, state_nxt;
  logic [31:0]     pc, pc_nxt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  entry_t          mem [DEPTH];
  entry_t          last;
  logic            fetch, push, pop, halt_hit;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Fetch qualification uses the registered count, so a same-cycle pop never
  // makes room for a push into a full queue.
  always_comb begin
    fetch = nrst && (state == RUN) && (count < CW'(DEPTH)) &&
            (pc <= LAST_ADDR) && !redirect_valid;
  end

  assign push        = fetch;
  assign pop         = issue_valid && issue_ready;
  assign rom_nrd     = !fetch;
  assign rom_addr    = pc;
  assign issue_valid = (count != '0);
  assign queue_count = count;

  // Head is combinational; when empty the last shown entry is held.
  assign issue_inst = issue_valid ? mem[rd_ptr].inst : last.inst;
  assign issue_pc   = issue_valid ? mem[rd_ptr].pc   : last.pc;

`ifdef HALT_DETECT_EN
  assign halt_hit = fetch && (rom_data == HALT_WORD);
`else
  assign halt_hit = 1'b0;
  logic unused_halt_word;
  assign unused_halt_word = ^HALT_WORD;
`endif

  // Next-state / next-PC; redirect has priority over everything but reset.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect_valid) begin
      state_nxt = RUN;
      pc_nxt    = {redirect_pc[31:2], 2'b00};
    end else begin
      case (state)
        RUN: begin
          if (fetch) begin
            pc_nxt = pc + 32'd4;
            if (halt_hit) state_nxt = DONE;
          end else if (pc > LAST_ADDR) begin
            state_nxt = DONE;
          end
        end
        DONE: state_nxt = DONE;
      endcase
    end
  end

  // State, PC and done flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= RUN;
      pc         <= RST_PC;
      fetch_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetch_done <= (state_nxt == DONE);
    end
  end

  // Queue pointers, occupancy and held head value.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (issue_valid) last <= mem[rd_ptr];
      if (redirect_valid) begin
        // A same-cycle handshake is considered consumed; the flush wins.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{inst: rom_data, pc: pc};
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned ROM_BYTES = 100;
  localparam int unsigned RESET_PC  = 0;
  localparam logic [31:0] LAST      = 32'(ROM_BYTES - 4);
  localparam logic [31:0] HALT      = 32'hFC00_0000;

  logic        clk;
  logic        nrst;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_inst;
  logic [31:0] issue_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_done;
  logic [2:0]  queue_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [ROM_BYTES];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    int i;
    i = int'(a);
    return {rom[i], rom[i+1], rom[i+2], rom[i+3]};
  endfunction

  function automatic void set_word(input int a, input logic [31:0] w);
    rom[a] = w[31:24]; rom[a+1] = w[23:16]; rom[a+2] = w[15:8]; rom[a+3] = w[7:0];
  endfunction

  assign rom_data = (rom_nrd == 1'b0 && rom_addr <= LAST) ? rom_word(rom_addr) : 32'h0BAD_0BAD;

  inst_fetch_queue #(.DEPTH(DEPTH), .ROM_BYTES(ROM_BYTES), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .nrst(nrst), .rom_nrd(rom_nrd), .rom_addr(rom_addr), .rom_data(rom_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
    .issue_pc(issue_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_done(fetch_done), .queue_count(queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: a queue of fetched entries plus PC and stopped flag.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_last_inst, m_last_pc;
  bit          m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 32'(RESET_PC);
    m_done = 1'b0;
    m_last_inst = '0;
    m_last_pc = '0;
  endtask

  // Compare all outputs with the model for this cycle, then advance one clock.
  task automatic cycle();
    bit fetch;
    logic [31:0] w;
    ent_t e;
    #1;
    fetch = nrst && !m_done && (mq.size() < DEPTH) && (m_pc <= LAST) && !redirect_valid;
    chk("rom_nrd", 32'(rom_nrd), 32'(!fetch));
    chk("rom_addr", rom_addr, m_pc);
    chk("issue_valid", 32'(issue_valid), 32'(mq.size() != 0));
    chk("issue_inst", issue_inst, (mq.size() != 0) ? mq[0].inst : m_last_inst);
    chk("issue_pc", issue_pc, (mq.size() != 0) ? mq[0].pc : m_last_pc);
    chk("fetch_done", 32'(fetch_done), 32'(m_done));
    chk("queue_count", 32'(queue_count), 32'(mq.size()));
    if (!nrst) begin
      model_reset();
    end else begin
      if (mq.size() != 0) begin
        m_last_inst = mq[0].inst;
        m_last_pc = mq[0].pc;
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_done = 1'b0;
      end else begin
        if (mq.size() != 0 && issue_ready) void'(mq.pop_front());
        if (fetch) begin
          w = rom_word(m_pc);
          e.inst = w;
          e.pc = m_pc;
          mq.push_back(e);
`ifdef HALT_DETECT_EN
          if (w == HALT) m_done = 1'b1;
`endif
          m_pc = m_pc + 32'd4;
        end else if (!m_done && m_pc > LAST) begin
          m_done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc = a;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w0;
    for (int i = 0; i < int'(ROM_BYTES); i++) rom[i] = 8'($urandom);
    set_word(8, 32'h1234_5678);
    nrst = 1'b0;
    issue_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_count", 32'(queue_count), 32'd0);
    chk("reset_valid", 32'(issue_valid), 32'd0);
    chk("reset_inst", issue_inst, 32'd0);
    chk("reset_pc", issue_pc, 32'd0);
    chk("reset_done", 32'(fetch_done), 32'd0);
    chk("reset_nrd", 32'(rom_nrd), 32'd1);

    // Fill with backpressure.
    nrst = 1'b1;
    w0 = rom_word(32'd0);
    repeat (6) cycle();
    chk("fill_count", 32'(queue_count), 32'd4);
    chk("fill_nrd", 32'(rom_nrd), 32'd1);
    chk("fill_head_pc", issue_pc, 32'd0);
    chk("fill_head_inst", issue_inst, w0);
    chk("fill_addr", rom_addr, 32'd16);

    // Steady state: full queue drains one, then push+pop per cycle.
    issue_ready = 1'b1;
    cycle();
    chk("steady_first_count", 32'(queue_count), 32'd3);
    chk("steady_first_pc", issue_pc, 32'd4);
    repeat (4) cycle();
    chk("steady_count", 32'(queue_count), 32'd3);
    chk("steady_pc", issue_pc, 32'd20);

    // Redirect with three entries queued and a same-cycle handshake.
    redirect_to(32'h22);
    #1;
    chk("redir_count", 32'(queue_count), 32'd0);
    chk("redir_valid", 32'(issue_valid), 32'd0);
    chk("redir_addr", rom_addr, 32'h20);
    chk("redir_refetch", 32'(rom_nrd), 32'd0);
    cycle();
    chk("redir_head_pc", issue_pc, 32'h20);

    // End of ROM.
    redirect_to(32'd88);
    repeat (6) cycle();
    chk("eor_done", 32'(fetch_done), 32'd1);
    chk("eor_nrd", 32'(rom_nrd), 32'd1);
    chk("eor_last_pc", issue_pc, 32'd96);
    redirect_to(32'd0);
    #1;
    chk("eor_clear", 32'(fetch_done), 32'd0);

    // Halt word at address 8.
    set_word(8, HALT);
    issue_ready = 1'b0;
    redirect_to(32'd0);
    repeat (6) cycle();
`ifdef HALT_DETECT_EN
    chk("halt_count", 32'(queue_count), 32'd3);
    chk("halt_done", 32'(fetch_done), 32'd1);
    chk("halt_addr", rom_addr, 32'd12);
`else
    chk("nohalt_count", 32'(queue_count), 32'd4);
    chk("nohalt_done", 32'(fetch_done), 32'd0);
    chk("nohalt_addr", rom_addr, 32'd16);
`endif

    // Reset mid-run with two entries queued.
    redirect_to(32'd40);
    repeat (2) cycle();
    chk("mid_count", 32'(queue_count), 32'd2);
    nrst = 1'b0;
    cycle();
    nrst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(queue_count), 32'd0);
    chk("mid_rst_valid", 32'(issue_valid), 32'd0);
    chk("mid_rst_addr", rom_addr, 32'(RESET_PC));
    chk("mid_rst_resume", 32'(rom_nrd), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < int'(ROM_BYTES); i += 4)
      set_word(i, ($urandom_range(0, 5) == 0) ? HALT : $urandom);
    for (int n = 0; n < 600; n++) begin
      issue_ready = ($urandom_range(0, 3) != 0);
      nrst = ($urandom_range(0, 60) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 20) == 0) ? $urandom : 32'($urandom_range(0, 120));
      cycle();
    end
    nrst = 1'b1;
    redirect_valid = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
